sram_like_arbiter: RTL

//   Shares one sram-like memory port between the IF-stage instruction requester and the
//   MEM-stage data requester, upstream of the AXI bridge.

---
 rtl/sram_like_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like port between instruction fetch and data access.
// Data has priority, bounded by a run limit; responses are routed through an in-order ID FIFO.
module sram_like_arbiter #(
  parameter int unsigned OUTSTANDING  = 4,
  parameter int unsigned MAX_DATA_RUN = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           inst_req,
  input  logic                           inst_wr,
  input  logic [1:0]                     inst_size,
  input  logic [3:0]                     inst_wstrb,
  input  logic [31:0]                    inst_addr,
  input  logic [31:0]                    inst_wdata,
  output logic                           inst_addr_ok,
  output logic                           inst_data_ok,
  output logic [31:0]                    inst_rdata,
  input  logic                           data_req,
  input  logic                           data_wr,
  input  logic [1:0]                     data_size,
  input  logic [3:0]                     data_wstrb,
  input  logic [31:0]                    data_addr,
  input  logic [31:0]                    data_wdata,
  output logic                           data_addr_ok,
  output logic                           data_data_ok,
  output logic [31:0]                    data_rdata,
  output logic                           mem_req,
  output logic                           mem_wr,
  output logic [1:0]                     mem_size,
  output logic [3:0]                     mem_wstrb,
  output logic [31:0]                    mem_addr,
  output logic [31:0]                    mem_wdata,
  input  logic                           mem_addr_ok,
  input  logic                           mem_data_ok,
  input  logic [31:0]                    mem_rdata,
  output logic [$clog2(OUTSTANDING):0]   outstanding_cnt
);

  localparam int unsigned PW = $clog2(OUTSTANDING);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned RW = $clog2(MAX_DATA_RUN + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOCK_I, S_LOCK_D} state_t;

  state_t                 r_state, w_next;
  logic [CW-1:0]          r_cnt;
  logic [PW-1:0]          r_wptr, r_rptr;
  logic [OUTSTANDING-1:0] r_ids;
  logic [RW-1:0]          r_run;

  logic w_full, w_empty, w_run_max;
  logic w_gnt_i, w_gnt_d, w_push, w_pop, w_head;

  assign w_full    = (r_cnt == CW'(OUTSTANDING));
  assign w_empty   = (r_cnt == '0);
  assign w_run_max = (r_run == RW'(MAX_DATA_RUN));

  always_comb begin
    w_gnt_i = 1'b0;
    w_gnt_d = 1'b0;
    w_next  = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_full) begin
          if (data_req && !(inst_req && w_run_max)) w_gnt_d = 1'b1;
          else if (inst_req)                         w_gnt_i = 1'b1;
        end
        if ((w_gnt_i || w_gnt_d) && !mem_addr_ok)
          w_next = w_gnt_i ? S_LOCK_I : S_LOCK_D;
      end
      S_LOCK_I: begin
        w_gnt_i = 1'b1;
        if (mem_addr_ok) w_next = S_IDLE;
      end
      S_LOCK_D: begin
        w_gnt_d = 1'b1;
        if (mem_addr_ok) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Everything visible is forced quiet while reset is asserted.
    if (reset) begin
      w_gnt_i = 1'b0;
      w_gnt_d = 1'b0;
    end
  end

  assign mem_req   = w_gnt_i | w_gnt_d;
  assign mem_wr    = w_gnt_d ? data_wr    : (w_gnt_i ? inst_wr    : 1'b0);
  assign mem_size  = w_gnt_d ? data_size  : (w_gnt_i ? inst_size  : '0);
  assign mem_wstrb = w_gnt_d ? data_wstrb : (w_gnt_i ? inst_wstrb : '0);
  assign mem_addr  = w_gnt_d ? data_addr  : (w_gnt_i ? inst_addr  : '0);
  assign mem_wdata = w_gnt_d ? data_wdata : (w_gnt_i ? inst_wdata : '0);

  assign w_push = mem_req & mem_addr_ok;
  assign w_pop  = mem_data_ok & ~w_empty & ~reset;
  assign w_head = r_ids[r_rptr];

  assign inst_addr_ok    = w_push & w_gnt_i;
  assign data_addr_ok    = w_push & w_gnt_d;
  assign inst_data_ok    = w_pop & ~w_head;
  assign data_data_ok    = w_pop & w_head;
  assign inst_rdata      = reset ? '0 : mem_rdata;
  assign data_rdata      = reset ? '0 : mem_rdata;
  assign outstanding_cnt = reset ? '0 : r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_ids   <= '0;
      r_run   <= '0;
    end else begin
      r_state <= w_next;
      if (w_push) begin
        r_ids[r_wptr] <= w_gnt_d;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      // Run length only counts data grants that actually made inst wait.
      if (inst_addr_ok || !inst_req)       r_run <= '0;
      else if (data_addr_ok && !w_run_max) r_run <= r_run + 1'b1;
    end
  end

endmodule
